// File: rtl/gshare_pht_ctrl.sv
// gshare PHT controller: GHR-hashed prediction through RAM port A and
// saturating read-modify-write counter updates through RAM port B.
module gshare_pht_ctrl #(
    parameter int ADDRLEN = 10,
    parameter int DATALEN = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pred_req,
    input  logic [31:0]        pred_pc,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic [ADDRLEN-1:0] pred_idx,
    output logic [ADDRLEN-1:0] pred_ghr,
    input  logic               upd_valid,
    output logic               upd_ready,
    input  logic [ADDRLEN-1:0] upd_idx,
    input  logic               upd_taken,
    input  logic               mispred,
    input  logic [ADDRLEN-1:0] mispred_ghr,
    input  logic               mispred_taken,
    output logic [ADDRLEN-1:0] pht_addra,
    input  logic [DATALEN-1:0] pht_rdataa,
    output logic [ADDRLEN-1:0] pht_addrb,
    input  logic [DATALEN-1:0] pht_rdatab,
    output logic [DATALEN-1:0] pht_wdatab,
    output logic               pht_webb,
    output logic               pht_clear
);

    // state | meaning
    // RD    | port B reads upd_idx; a new update may be accepted
    // WR    | port B writes the saturated counter of the latched update
    typedef enum logic {ST_RD = 1'b0, ST_WR = 1'b1} upd_state_t;

    upd_state_t         state, state_nxt;
    logic [ADDRLEN-1:0] ghr, ghr_eff, hash_idx;
    logic [ADDRLEN-1:0] upd_idx_q;
    logic               upd_taken_q;
    logic               upd_accept;
    logic [DATALEN-1:0] sat_val;
    logic               unused_bits;

    // the in-flight prediction has not reached the GHR yet, so forward it
    assign ghr_eff    = pred_valid ? {ghr[ADDRLEN-2:0], pred_taken} : ghr;
    assign hash_idx   = pred_pc[ADDRLEN+1:2] ^ ghr_eff;
    assign pht_addra  = hash_idx;
    assign pred_taken = pred_valid & pht_rdataa[DATALEN-1];
    assign pht_clear  = reset;
    assign pht_wdatab = sat_val;

    assign unused_bits = ^{pred_pc[31:ADDRLEN+2], pred_pc[1:0],
                           pht_rdataa[DATALEN-2:0], mispred_ghr[ADDRLEN-1]};

    always_comb begin
        sat_val = pht_rdatab;
        if (upd_taken_q) begin
            if (pht_rdatab != '1) sat_val = pht_rdatab + 1'b1;
        end else if (pht_rdatab != '0) begin
            sat_val = pht_rdatab - 1'b1;
        end
    end

    always_comb begin
        state_nxt  = state;
        upd_ready  = 1'b0;
        upd_accept = 1'b0;
        pht_addrb  = upd_idx;
        pht_webb   = 1'b0;
        case (state)
            ST_RD: begin
                upd_ready  = !reset;
                upd_accept = upd_valid && !reset;
                if (upd_accept) state_nxt = ST_WR;
            end
            ST_WR: begin
                pht_addrb = upd_idx_q;
                pht_webb  = !reset;
                state_nxt = ST_RD;
            end
            default: state_nxt = ST_RD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ghr         <= '0;
            pred_valid  <= 1'b0;
            pred_idx    <= '0;
            pred_ghr    <= '0;
            state       <= ST_RD;
            upd_idx_q   <= '0;
            upd_taken_q <= 1'b0;
        end else begin
            // recovery wins; the mispredicted cycle's own shift is discarded
            if (mispred)
                ghr <= {mispred_ghr[ADDRLEN-2:0], mispred_taken};
            else if (pred_valid)
                ghr <= {ghr[ADDRLEN-2:0], pred_taken};
            pred_valid <= pred_req && !mispred;
            if (pred_req && !mispred) begin
                pred_idx <= hash_idx;
                pred_ghr <= ghr_eff;
            end
            state <= state_nxt;
            if (upd_accept) begin
                upd_idx_q   <= upd_idx;
                upd_taken_q <= upd_taken;
            end
        end
    end

endmodule

// File: tb/tb_gshare_pht_ctrl.sv
// Scoreboard bench for gshare_pht_ctrl with a behavioural PHT RAM and an
// integer-arithmetic reference model of counters and history.
module tb_gshare_pht_ctrl;
    localparam int AL = 10;

    logic          clk = 1'b0;
    logic          reset, pred_req, upd_valid, upd_taken, mispred, mispred_taken;
    logic [31:0]   pred_pc;
    logic [AL-1:0] upd_idx, mispred_ghr;
    logic          pred_valid, pred_taken, upd_ready, pht_webb, pht_clear;
    logic [AL-1:0] pred_idx, pred_ghr, pht_addra, pht_addrb;
    logic [1:0]    pht_rdataa, pht_rdatab, pht_wdatab;

    int n_checks = 0;
    int n_errors = 0;
    bit started  = 0;

    always #5 clk = ~clk;

    gshare_pht_ctrl #(.ADDRLEN(AL), .DATALEN(2)) dut (
        .clk(clk), .reset(reset),
        .pred_req(pred_req), .pred_pc(pred_pc),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .pred_idx(pred_idx), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_idx(upd_idx), .upd_taken(upd_taken),
        .mispred(mispred), .mispred_ghr(mispred_ghr), .mispred_taken(mispred_taken),
        .pht_addra(pht_addra), .pht_rdataa(pht_rdataa),
        .pht_addrb(pht_addrb), .pht_rdatab(pht_rdatab),
        .pht_wdatab(pht_wdatab), .pht_webb(pht_webb), .pht_clear(pht_clear)
    );

    // dual-port RAM, registered read-first outputs, bulk clear
    logic [1:0] mem [0:1023];
    always @(posedge clk) begin
        pht_rdataa <= mem[pht_addra];
        pht_rdatab <= mem[pht_addrb];
        if (pht_clear) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 2'b00;
        end else if (pht_webb) begin
            mem[pht_addrb] <= pht_wdatab;
        end
    end

    // reference model
    typedef struct { int idx; int ghr; int taken; } pred_t;
    typedef struct { int idx; int val; } wr_t;
    pred_t pq[$];
    wr_t   wq[$];
    int    m_cnt [1024];
    int    m_ghr = 0;
    bit    m_pv = 0, m_pt = 0, m_busy = 0;
    int    m_pidx = 0, m_pval = 0;

    function automatic int ghr_eff_m();
        return m_pv ? ((m_ghr * 2 + int'(m_pt)) % 1024) : m_ghr;
    endfunction

    function automatic int pc_idx(input logic [31:0] pc);
        return int'((pc >> 2) & 32'h3FF);
    endfunction

    always @(posedge clk) begin : model
        int eff, idx, nxt, c;
        bit npv, npt;
        if (reset) begin
            m_ghr = 0; m_pv = 0; m_pt = 0; m_busy = 0;
            foreach (m_cnt[i]) m_cnt[i] = 0;
            pq.delete();
            wq.delete();
        end else begin
            eff = ghr_eff_m();
            npv = 0;
            npt = 0;
            if (pred_req && !mispred) begin
                idx = pc_idx(pred_pc) ^ eff;
                npv = 1;
                npt = (m_cnt[idx] >= 2);
                pq.push_back('{idx, eff, int'(npt)});
            end
            if (mispred)   nxt = (int'(mispred_ghr) * 2 + int'(mispred_taken)) % 1024;
            else if (m_pv) nxt = (m_ghr * 2 + int'(m_pt)) % 1024;
            else           nxt = m_ghr;
            if (m_busy) begin
                m_cnt[m_pidx] = m_pval;
                m_busy = 0;
            end else if (upd_valid) begin
                m_pidx = int'(upd_idx);
                c = m_cnt[m_pidx];
                m_pval = upd_taken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
                m_busy = 1;
                wq.push_back('{m_pidx, m_pval});
            end
            m_ghr = nxt; m_pv = npv; m_pt = npt;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor
    always @(negedge clk) begin : monitor
        pred_t p;
        wr_t   w;
        if (started) begin
            chk("pht_clear", 32'(pht_clear), 32'(reset));
            chk("upd_ready", 32'(upd_ready), 32'(!reset && !m_busy));
            chk("pht_webb", 32'(pht_webb), 32'(!reset && m_busy));
            chk("pred_valid", 32'(pred_valid), 32'(m_pv));
            if (!reset)
                chk("pht_addra", 32'(pht_addra), 32'(pc_idx(pred_pc) ^ ghr_eff_m()));
            if (pred_valid) begin
                if (pq.size() == 0) begin
                    chk("pred_unexpected", 32'(pred_valid), 32'd0);
                end else begin
                    p = pq.pop_front();
                    chk("pred_idx", 32'(pred_idx), 32'(p.idx));
                    chk("pred_ghr", 32'(pred_ghr), 32'(p.ghr));
                    chk("pred_taken", 32'(pred_taken), 32'(p.taken));
                end
            end
            if (pht_webb) begin
                if (wq.size() == 0) begin
                    chk("write_unexpected", 32'(pht_webb), 32'd0);
                end else begin
                    w = wq.pop_front();
                    chk("pht_addrb", 32'(pht_addrb), 32'(w.idx));
                    chk("pht_wdatab", 32'(pht_wdatab), 32'(w.val));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_req = 0; upd_valid = 0; mispred = 0;
    endtask

    task automatic do_update(input int idx, input bit t);
        bit got;
        got = 0;
        upd_valid = 1; upd_idx = AL'(idx); upd_taken = t;
        for (int k = 0; k < 8 && !got; k++) begin
            @(negedge clk);
            got = upd_ready;
            tick();
        end
        upd_valid = 0;
        chk("upd_accept_timeout", 32'(got), 32'd1);
    endtask

    function automatic logic [31:0] pc_for(input int idx);
        return 32'((idx ^ ghr_eff_m()) << 2);
    endfunction

    initial begin
        foreach (mem[i]) mem[i] = 2'($urandom);
        reset = 1; pred_pc = 0; upd_idx = 0; upd_taken = 0;
        mispred_ghr = 0; mispred_taken = 0;
        idle();
        tick();
        started = 1;
        tick(); tick();
        reset = 0;

        // first prediction after reset
        pred_req = 1; pred_pc = 32'h100;
        tick();
        pred_req = 0;
        @(negedge clk);
        chk("first_pred_valid", 32'(pred_valid), 32'd1);
        chk("first_pred_idx", 32'(pred_idx), 32'h040);
        chk("first_pred_ghr", 32'(pred_ghr), 32'h000);
        chk("first_pred_taken", 32'(pred_taken), 32'd0);
        tick();

        // saturation up and down at idx 5
        for (int i = 0; i < 4; i++) do_update(5, 1);
        for (int i = 0; i < 4; i++) do_update(5, 0);
        tick();

        // counter at 0x040 to strongly taken, then consecutive predictions
        for (int i = 0; i < 3; i++) do_update(32'h40, 1);
        tick();
        pred_req = 1; pred_pc = 32'h100;
        tick();
        pred_pc = 32'h200;
        @(negedge clk);
        chk("fwd_addra", 32'(pht_addra), 32'h081);
        tick();
        pred_req = 0;
        @(negedge clk);
        chk("fwd_pred_ghr", 32'(pred_ghr), 32'h001);
        tick();

        // mispredict while a prediction is valid
        pred_req = 1; pred_pc = 32'h3C4;
        tick();
        mispred = 1; mispred_ghr = 10'h2AA; mispred_taken = 1; pred_req = 1;
        tick();
        mispred = 0; pred_req = 0; pred_pc = 32'h0;
        @(negedge clk);
        chk("mispred_drop", 32'(pred_valid), 32'd0);
        chk("mispred_ghr", 32'(pht_addra), 32'h155);
        tick();

        // port A/B collision on idx 7: counter 1 -> 2 written during prediction
        do_update(7, 1);
        tick();
        do_update(7, 1);
        pred_req = 1; pred_pc = pc_for(7);
        tick();
        pred_pc = pc_for(7);
        @(negedge clk);
        chk("stale_pred_taken", 32'(pred_taken), 32'd0);
        tick();
        pred_req = 0;
        @(negedge clk);
        chk("fresh_pred_taken", 32'(pred_taken), 32'd1);
        tick();

        // reset during the WR cycle
        do_update(9, 1);
        reset = 1;
        @(negedge clk);
        chk("reset_wr_webb", 32'(pht_webb), 32'd0);
        tick();
        reset = 0;
        pred_req = 1; pred_pc = pc_for(9);
        tick();
        pred_req = 0;
        tick();

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            reset         = ($urandom_range(0, 199) == 0);
            pred_req      = 1'($urandom_range(0, 1));
            pred_pc       = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 15)) << 2);
            upd_valid     = ($urandom_range(0, 2) != 0);
            upd_idx       = AL'($urandom_range(0, 15));
            upd_taken     = 1'($urandom_range(0, 1));
            mispred       = ($urandom_range(0, 9) == 0);
            mispred_ghr   = AL'($urandom);
            mispred_taken = 1'($urandom_range(0, 1));
            tick();
        end
        reset = 0;
        idle();
        repeat (5) tick();
        chk("pred_queue_drained", 32'(pq.size()), 32'd0);
        chk("write_queue_drained", 32'(wq.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
